// File: rtl/hid_keycode_packer.sv
// Packs 8-byte USB HID boot-keyboard reports from a byte stream into a 32-bit keycode bus.
// Define FRAME_SYNC_EN to publish only on frame_clk rising edges; otherwise publish right after commit.
module hid_keycode_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sop,
  output logic        rx_ready,
  input  logic        frame_clk,
  output logic [31:0] keycode,
  output logic [7:0]  modifier,
  output logic        report_err,
  output logic        key_change
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BODY, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    n_q, n_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [7:0]    smod_q, smod_d;
  logic          erovr_q, erovr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pend_kc_q, pend_kc_d;
  logic [7:0]    pend_mod_q, pend_mod_d;
  logic [31:0]   out_kc_q, out_kc_d;
  logic [7:0]    out_mod_q, out_mod_d;
  logic          err_q, err_d;
  logic          chg_q, chg_d;
  logic          accept;
  logic          publish;

  assign rx_ready   = (state_q != DONE);
  assign accept     = rx_valid && rx_ready;
  assign keycode    = out_kc_q;
  assign modifier   = out_mod_q;
  assign report_err = err_q;
  assign key_change = chg_q;

`ifdef FRAME_SYNC_EN
  logic f_q;
  always_ff @(posedge Clk) begin
    if (Reset) f_q <= 1'b0;
    else       f_q <= frame_clk;
  end
  assign publish = frame_clk && !f_q;
`else
  logic unused_frame;
  assign unused_frame = frame_clk;
  assign publish      = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    shadow_d   = shadow_q;
    smod_d     = smod_q;
    erovr_d    = erovr_q;
    cnt_d      = cnt_q;
    pend_kc_d  = pend_kc_q;
    pend_mod_d = pend_mod_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept && rx_sop) begin
          smod_d   = rx_data;
          idx_d    = 3'd1;
          n_d      = 3'd0;
          shadow_d = '0;
          erovr_d  = 1'b0;
          state_d  = BODY;
        end
      end
      BODY: begin
        if (accept) begin
          cnt_d = '0;
          if (rx_sop) begin
            // A fresh byte 0 restarts the report; the partial one is reported as an error.
            err_d    = 1'b1;
            smod_d   = rx_data;
            idx_d    = 3'd1;
            n_d      = 3'd0;
            shadow_d = '0;
            erovr_d  = 1'b0;
          end else begin
            if (idx_q == 3'd2) erovr_d = (rx_data == 8'h01);
            if (idx_q >= 3'd2 && rx_data != 8'h00 && n_q < 3'd4) begin
              shadow_d[{n_q[1:0], 3'b000} +: 8] = rx_data;
              n_d = n_q + 3'd1;
            end
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = DONE;
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        cnt_d = '0;
        if (erovr_q) begin
          err_d = 1'b1;
        end else begin
          pend_kc_d  = shadow_q;
          pend_mod_d = smod_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_kc_d  = out_kc_q;
    out_mod_d = out_mod_q;
    chg_d     = 1'b0;
    if (publish) begin
      out_kc_d  = pend_kc_q;
      out_mod_d = pend_mod_q;
      chg_d     = ({pend_kc_q, pend_mod_q} != {out_kc_q, out_mod_q});
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      shadow_q   <= '0;
      smod_q     <= '0;
      erovr_q    <= 1'b0;
      cnt_q      <= '0;
      pend_kc_q  <= '0;
      pend_mod_q <= '0;
      out_kc_q   <= '0;
      out_mod_q  <= '0;
      err_q      <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      shadow_q   <= shadow_d;
      smod_q     <= smod_d;
      erovr_q    <= erovr_d;
      cnt_q      <= cnt_d;
      pend_kc_q  <= pend_kc_d;
      pend_mod_q <= pend_mod_d;
      out_kc_q   <= out_kc_d;
      out_mod_q  <= out_mod_d;
      err_q      <= err_d;
      chg_q      <= chg_d;
    end
  end

endmodule

// File: doc/hid_keycode_packer.md
# hid_keycode_packer

Converts the byte stream of 8-byte USB HID boot-keyboard reports, delivered by the host-interface byte port, into the packed 32-bit `keycode` bus consumed by the tank movement modules. Nonzero key slots are compacted, ErrorRollOver and truncated reports are rejected, and the published value is frame-synchronous so every tank sees one stable keycode per frame. Sits between the USB host byte port and all `keycode` consumers.

## Interface
- `TIMEOUT_CYCLES`, 1_000_000: max Clk cycles between accepted bytes inside one report before it is aborted.
- `Clk`  input  1  system clock; all logic on rising edge.
- `Reset`  input  1  synchronous, active-high reset.
- `rx_data`  input  8  report byte.
- `rx_valid`  input  1  `rx_data` valid.
- `rx_sop`  input  1  qualifies `rx_data` as byte 0 (modifier) of a report.
- `rx_ready`  output  1  block can accept a byte; transfer when `rx_valid && rx_ready`.
- `frame_clk`  input  1  vertical-sync level, sampled as data in the Clk domain.
- `keycode`  output  32  up to 4 pressed keys; first key in [7:0], fourth in [31:24]; 0x00 = empty slot.
- `modifier`  output  8  report byte 0 (Ctrl/Shift/Alt/GUI bits).
- `report_err`  output  1  one-cycle pulse on any rejected/aborted report.
- `key_change`  output  1  one-cycle pulse when `keycode` or `modifier` output changes value.

## Operation
- Report layout: byte 0 modifier, byte 1 reserved (ignored), bytes 2–7 key slots.
- FSM states: IDLE, BODY, DONE. Reset -> IDLE.
- IDLE: `rx_ready`=1. Accepted byte with `rx_sop`=1 -> store modifier, byte index=1, -> BODY. Accepted byte without `rx_sop`: dropped, no error.
- BODY: `rx_ready`=1. Each accepted byte increments index (3-bit). Index 1 discarded. Indices 2–7: if byte ≠ 0x00 and fewer than 4 keys stored, append to shadow slot `n`, `n`++; else drop. Byte 5th–6th nonzero keys silently dropped. Accepting index 7 -> DONE.
- Accepted byte with `rx_sop`=1 while in BODY: current report aborted, `report_err` pulse, byte taken as new byte 0, stay BODY with index=1, shadow cleared.
- Timeout: inactivity counter cleared on each accepted byte; reaching `TIMEOUT_CYCLES` in BODY -> abort, `report_err` pulse, -> IDLE. Counter held at 0 outside BODY.
- DONE (one cycle, `rx_ready`=0): if byte 2 was 0x01 (ErrorRollOver) -> discard, `report_err` pulse, pending unchanged. Otherwise copy shadow {slots, modifier} into pending register, unused slots 0x00. -> IDLE.
- Publish: pending -> `keycode`/`modifier` outputs per Configuration. `key_change` pulses in the cycle after the outputs take a different value; identical reports produce no pulse.
- Reset mid-report: shadow, pending, outputs, counters cleared; partial report lost, no `report_err`.

## Timing
- Reset values: `keycode`=0, `modifier`=0, `report_err`=0, `key_change`=0, `rx_ready`=1 (IDLE).
- Byte 7 accepted at edge N -> DONE during cycle N..N+1 -> pending valid after edge N+1.
- `report_err`: high for exactly the cycle following the rejecting edge.
- `frame_clk` registered once (`f_q`); rise = `frame_clk && !f_q`.
- Commit into pending and publish in the same edge: output takes the old pending value; new value published at next publish event.
- Throughput: one byte per cycle; minimum 9 cycles per report (8 bytes + DONE).

## Configuration
- `FRAME_SYNC_EN` defined: outputs load pending on the edge where rise is detected; value stable from frame to frame; visible one cycle after the `frame_clk` rising edge is sampled.
- Undefined: outputs load pending on the edge after commit (byte 7 at edge N -> outputs valid after edge N+2); `frame_clk` ignored.

## Test plan
- Report {00,00,1A,00,04,00,00,00} then frame edge -> `keycode`=0x0000041A, `modifier`=0x00, one `key_change` pulse.
- Report {02,00,52,51,50,4F,2C,28} -> `keycode`=0x4F505152, `modifier`=0x02; 0x2C,0x28 dropped, no error.
- Report {00,00,01,01,01,01,01,01} after a valid report -> `report_err` one pulse, `keycode` unchanged, no `key_change`.
- 4 bytes then `rx_sop` byte 0x00 plus 7 zero bytes -> one `report_err`, `keycode`=0x00000000 published.
- 3 bytes then idle `TIMEOUT_CYCLES` -> `report_err` at count expiry, FSM in IDLE, next non-sop bytes ignored.
- With `FRAME_SYNC_EN`: two reports committed between frame edges -> only the second published, single `key_change`; Reset asserted mid-report -> all outputs 0, `rx_ready`=1.
